// File: rtl/ifc_pkg.sv
// Shared definitions for the IFC receive path: FSM states, result codes and header layout.
package ifc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHK     = 2'd2,
    REPORT  = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CHK  = 2'd1;
  localparam logic [1:0] ERR_LEN  = 2'd2;
  localparam logic [1:0] ERR_SYNC = 2'd3;

  localparam int LEN_MSB  = 11;
  localparam int TYPE_LSB = 12;

  function automatic logic [LEN_MSB:0] hdr_len(input logic [15:0] w);
    return w[LEN_MSB:0];
  endfunction

endpackage

// File: rtl/ifc_xor_acc.sv
// 16-bit XOR accumulator; load has priority over clear, clear over accumulate.
module ifc_xor_acc (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_en,
  input  logic        i_clear,
  input  logic [15:0] i_d,
  output logic [15:0] o_q
);

  logic [15:0] r_acc;

  always_ff @(posedge clk) begin
    if (rst)          r_acc <= '0;
    else if (i_load)  r_acc <= i_d;
    else if (i_clear) r_acc <= '0;
    else if (i_en)    r_acc <= r_acc ^ i_d;
  end

  assign o_q = r_acc;

endmodule

// File: rtl/ifc_frame_ctrl.sv
// IFC receive frame sequencer: header/payload/checksum parsing, result reporting,
// sync/timeout abort and saturating good/bad frame counters.
module ifc_frame_ctrl
  import ifc_pkg::*;
#(
  parameter int MAX_LEN = 256,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [15:0]      s_data,
  input  logic             s_sof,
  output logic             res_valid,
  output logic             res_ok,
  output logic [1:0]       res_err,
  output logic [11:0]      res_len,
  output logic [15:0]      res_checksum,
  output logic             busy,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_t             r_state, r_after;
  logic               r_ready, r_busy, r_valid, r_ok;
  logic [1:0]         r_err;
  logic [11:0]        r_res_len, r_len, r_cnt;
  logic [15:0]        r_res_chk;
  logic [TMO_W-1:0]   r_tmo;
  logic [CNT_W-1:0]   r_ok_cnt, r_err_cnt;

  logic               w_hs, w_sof_hs, w_word_hs, w_hdr_bad, w_sum_ok;
  logic               w_load, w_en, w_clear;
  logic [11:0]        w_hdr_len, w_cnt_nxt;
  logic [15:0]        w_acc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_hs      = s_valid & r_ready;
  assign w_sof_hs  = w_hs & s_sof;
  assign w_word_hs = w_hs & ~s_sof;
  assign w_hdr_len = hdr_len(s_data);
  assign w_hdr_bad = 32'(w_hdr_len) > 32'(MAX_LEN);
  assign w_cnt_nxt = r_cnt + 12'd1;
  assign w_sum_ok  = (s_data == w_acc);

  // A sof word always starts a new checksum, whatever state it arrives in.
  assign w_load  = w_sof_hs && (r_state != REPORT);
  assign w_en    = w_word_hs && (r_state == PAYLOAD);
  assign w_clear = (r_state == REPORT) && (r_after == IDLE);

  ifc_xor_acc u_acc (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_en    (w_en),
    .i_clear (w_clear),
    .i_d     (s_data),
    .o_q     (w_acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_after   <= IDLE;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_ok      <= 1'b0;
      r_err     <= ERR_NONE;
      r_res_len <= '0;
      r_res_chk <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_tmo     <= '0;
      r_ok_cnt  <= '0;
      r_err_cnt <= '0;
    end else begin
      r_valid <= 1'b0;
      r_ready <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_sof_hs) begin
            r_len   <= w_hdr_len;
            r_cnt   <= '0;
            r_tmo   <= '0;
            r_busy  <= 1'b1;
            r_after <= IDLE;
            if (w_hdr_bad) begin
              r_state   <= REPORT;
              r_valid   <= 1'b1;
              r_ready   <= 1'b0;
              r_ok      <= 1'b0;
              r_err     <= ERR_LEN;
              r_res_len <= w_hdr_len;
              r_res_chk <= s_data;
              r_err_cnt <= sat_inc(r_err_cnt);
            end else if (w_hdr_len == 12'd0) begin
              r_state <= CHK;
            end else begin
              r_state <= PAYLOAD;
            end
          end
        end
        PAYLOAD, CHK: begin
          if (w_sof_hs) begin
            // Abort reports the old frame; the sof word becomes the next header.
            r_state   <= REPORT;
            r_valid   <= 1'b1;
            r_ready   <= 1'b0;
            r_ok      <= 1'b0;
            r_err     <= ERR_SYNC;
            r_res_len <= r_len;
            r_res_chk <= w_acc;
            r_err_cnt <= sat_inc(r_err_cnt);
            r_len     <= w_hdr_len;
            r_cnt     <= '0;
            r_tmo     <= '0;
            if (w_hdr_bad)                r_after <= REPORT;
            else if (w_hdr_len == 12'd0)  r_after <= CHK;
            else                          r_after <= PAYLOAD;
          end else if (w_word_hs) begin
            r_tmo <= '0;
            if (r_state == PAYLOAD) begin
              r_cnt <= w_cnt_nxt;
              if (w_cnt_nxt == r_len) r_state <= CHK;
            end else begin
              r_state   <= REPORT;
              r_after   <= IDLE;
              r_valid   <= 1'b1;
              r_ready   <= 1'b0;
              r_ok      <= w_sum_ok;
              r_err     <= w_sum_ok ? ERR_NONE : ERR_CHK;
              r_res_len <= r_len;
              r_res_chk <= w_acc;
              if (w_sum_ok) r_ok_cnt  <= sat_inc(r_ok_cnt);
              else          r_err_cnt <= sat_inc(r_err_cnt);
            end
          end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
            r_state   <= REPORT;
            r_after   <= IDLE;
            r_valid   <= 1'b1;
            r_ready   <= 1'b0;
            r_ok      <= 1'b0;
            r_err     <= ERR_SYNC;
            r_res_len <= r_len;
            r_res_chk <= w_acc;
            r_err_cnt <= sat_inc(r_err_cnt);
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        REPORT: begin
          if (r_after == REPORT) begin
            // Header consumed during a sync abort was itself over-length.
            r_after   <= IDLE;
            r_valid   <= 1'b1;
            r_ready   <= 1'b0;
            r_ok      <= 1'b0;
            r_err     <= ERR_LEN;
            r_res_len <= r_len;
            r_res_chk <= w_acc;
            r_err_cnt <= sat_inc(r_err_cnt);
          end else begin
            r_state <= r_after;
            r_tmo   <= '0;
            r_busy  <= (r_after != IDLE);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_ready      = r_ready;
  assign busy         = r_busy;
  assign res_valid    = r_valid;
  assign res_ok       = r_ok;
  assign res_err      = r_err;
  assign res_len      = r_res_len;
  assign res_checksum = r_res_chk;
  assign ok_cnt       = r_ok_cnt;
  assign err_cnt      = r_err_cnt;

endmodule

// File: tb/tb_ifc_frame_ctrl.sv
// Directed bench for ifc_frame_ctrl with hand-computed expected results.
module tb_ifc_frame_ctrl;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid, s_ready, s_sof;
  logic [15:0]      s_data;
  logic             res_valid, res_ok, busy;
  logic [1:0]       res_err;
  logic [11:0]      res_len;
  logic [15:0]      res_checksum;
  logic [CNT_W-1:0] ok_cnt, err_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int vcount  = 0;

  ifc_frame_ctrl #(.MAX_LEN(256), .TIMEOUT(16), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_sof        (s_sof),
    .res_valid    (res_valid),
    .res_ok       (res_ok),
    .res_err      (res_err),
    .res_len      (res_len),
    .res_checksum (res_checksum),
    .busy         (busy),
    .ok_cnt       (ok_cnt),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (res_valid === 1'b1) vcount++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits (bounded) for s_ready, then performs one handshake; returns #1 after that edge.
  task automatic send(input logic [15:0] d, input logic sof);
    int w;
    w = 0;
    while (s_ready !== 1'b1 && w < 50) begin
      tick(1);
      w++;
    end
    if (w >= 50) check_eq("ready_wait", 32'(s_ready), 32'd1);
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  initial begin
    int i;
    rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_data = '0;
    tick(3);
    check_eq("rst_ready", 32'(s_ready), 0);
    check_eq("rst_valid", 32'(res_valid), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_okcnt", 32'(ok_cnt), 0);
    check_eq("rst_errcnt", 32'(err_cnt), 0);
    rst = 1'b0;
    tick(1);
    check_eq("ready_after_rst", 32'(s_ready), 1);

    // Good frame: 0x1003^0x1111^0x2222^0x4444 = 0x6774
    send(16'h1003, 1); send(16'h1111, 0); send(16'h2222, 0); send(16'h4444, 0);
    check_eq("good_no_early_valid", 32'(res_valid), 0);
    check_eq("good_busy", 32'(busy), 1);
    send(16'h6774, 0);
    check_eq("good_valid", 32'(res_valid), 1);
    check_eq("good_ok", 32'(res_ok), 1);
    check_eq("good_err", 32'(res_err), 0);
    check_eq("good_len", 32'(res_len), 3);
    check_eq("good_chk", 32'(res_checksum), 32'h6774);
    check_eq("good_okcnt", 32'(ok_cnt), 1);
    check_eq("good_report_ready", 32'(s_ready), 0);
    tick(1);
    check_eq("good_pulse_end", 32'(res_valid), 0);
    check_eq("good_len_hold", 32'(res_len), 3);
    check_eq("good_idle_busy", 32'(busy), 0);

    // Zero-length frames, correct then wrong checksum
    send(16'h5000, 1); send(16'h5000, 0);
    check_eq("zl_ok", 32'(res_ok), 1);
    check_eq("zl_len", 32'(res_len), 0);
    check_eq("zl_chk", 32'(res_checksum), 32'h5000);
    send(16'h5000, 1); send(16'h5001, 0);
    check_eq("zl_bad_err", 32'(res_err), 1);
    check_eq("zl_bad_errcnt", 32'(err_cnt), 1);
    check_eq("zl_okcnt", 32'(ok_cnt), 2);

    // Bad checksum
    send(16'h1003, 1); send(16'h1111, 0); send(16'h2222, 0); send(16'h4444, 0);
    send(16'h6775, 0);
    check_eq("bad_valid", 32'(res_valid), 1);
    check_eq("bad_ok", 32'(res_ok), 0);
    check_eq("bad_err", 32'(res_err), 1);
    check_eq("bad_chk", 32'(res_checksum), 32'h6774);
    check_eq("bad_errcnt", 32'(err_cnt), 2);

    // Length error: 0x101 = 257 > 256
    send(16'h0101, 1);
    check_eq("len_valid", 32'(res_valid), 1);
    check_eq("len_err", 32'(res_err), 2);
    check_eq("len_len", 32'(res_len), 32'h101);
    check_eq("len_errcnt", 32'(err_cnt), 3);
    send(16'h1234, 0); send(16'h5678, 0);
    tick(4);
    check_eq("drop_busy", 32'(busy), 0);
    check_eq("drop_vcount", vcount, 5);

    // Timeout: result exactly 16 cycles after the last handshake
    send(16'h1003, 1); send(16'h1111, 0);
    i = 0;
    while (res_valid !== 1'b1 && i < 40) begin
      tick(1);
      i++;
    end
    check_eq("tmo_latency", i, 16);
    check_eq("tmo_err", 32'(res_err), 3);
    check_eq("tmo_errcnt", 32'(err_cnt), 4);
    tick(1);
    check_eq("tmo_busy", 32'(busy), 0);

    // Sync error, then the sof word heads a good frame: 0x2001^0x00AA = 0x20AB
    send(16'h1003, 1); send(16'h1111, 0); send(16'h2001, 1);
    check_eq("sync_valid", 32'(res_valid), 1);
    check_eq("sync_err", 32'(res_err), 3);
    check_eq("sync_errcnt", 32'(err_cnt), 5);
    send(16'h00AA, 0); send(16'h20AB, 0);
    check_eq("sync_next_ok", 32'(res_ok), 1);
    check_eq("sync_next_len", 32'(res_len), 1);
    check_eq("sync_next_chk", 32'(res_checksum), 32'h20AB);
    check_eq("sync_next_okcnt", 32'(ok_cnt), 3);
    tick(2);
    check_eq("total_vcount", vcount, 8);

    // Reset mid-payload
    send(16'h1003, 1); send(16'h1111, 0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_eq("mrst_busy", 32'(busy), 0);
    check_eq("mrst_valid", 32'(res_valid), 0);
    check_eq("mrst_len", 32'(res_len), 0);
    check_eq("mrst_chk", 32'(res_checksum), 0);
    check_eq("mrst_err", 32'(res_err), 0);
    check_eq("mrst_okcnt", 32'(ok_cnt), 0);
    check_eq("mrst_errcnt", 32'(err_cnt), 0);
    tick(30);
    check_eq("mrst_no_result", vcount, 8);
    check_eq("mrst_ready", 32'(s_ready), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
